model_tick_ctrl: RTL and testbench

Run/pause/single-step controller for the model clock of the FPGA build of `moody_mimosa`. It replaces the fixed power-of-two divider that drives `ui_in[0]`. It generates a square-wave model clock with a programmable period, and accepts byte commands from the UART receive path to run, pause, single-step and reconfigure it. It also keeps a wrapping count of model ticks for status readback over UART.

---
 rtl/model_tick_pkg.sv | 29 ++
 rtl/model_clk_prescaler.sv | 58 +++++
 rtl/model_tick_ctrl.sv | 105 ++++++++++
 tb/tb_model_tick_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_tick_pkg.sv
// Shared constants, state encoding and half-period helper for the model clock
// run/pause/step controller.
package model_tick_pkg;

   localparam int SHIFT_W = 5;
   localparam int CNT_W   = 16;
   localparam int HALF_W  = 31;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_RUN   = 3'b001;
   localparam logic [2:0] OP_PAUSE = 3'b010;
   localparam logic [2:0] OP_STEP  = 3'b011;
   localparam logic [2:0] OP_SHIFT = 3'b100;
   localparam logic [2:0] OP_CLR   = 3'b101;

   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      DRAIN  = 2'd3
   } state_e;

   // Terminal half-period count h-1 with h = 2^(shift-1); shift 0 behaves as 1.
   function automatic logic [HALF_W-1:0] half_max(input logic [SHIFT_W-1:0] shift);
      if (shift <= 5'd1) return '0;
      return (HALF_W'(1) << (shift - 5'd1)) - HALF_W'(1);
   endfunction

endpackage

// File: rtl/model_clk_prescaler.sv
// Square-wave generator: half-period counter with >= terminal compare, toggling
// model_clk and emitting registered rise (tick) and fall pulses.
module model_clk_prescaler
   import model_tick_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [SHIFT_W-1:0] shift_i,
   input  logic               enable_i,
   output logic               model_clk_o,
   output logic               tick_o,
   output logic               fall_o
);

   logic [HALF_W-1:0] cnt_q, cnt_d;
   logic              clk_q, clk_d;
   logic              tick_q, tick_d;
   logic              fall_q, fall_d;
   logic              wrap;

   always_comb begin
      wrap   = (cnt_q >= half_max(shift_i));
      cnt_d  = cnt_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      fall_d = 1'b0;
      if (!enable_i) begin
         cnt_d = '0;
      end else if (wrap) begin
         // >= lets a shrinking shift toggle immediately instead of wrapping the counter.
         cnt_d  = '0;
         clk_d  = ~clk_q;
         tick_d = ~clk_q;
         fall_d = clk_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
         fall_q <= fall_d;
      end
   end

   assign model_clk_o = clk_q;
   assign tick_o      = tick_q;
   assign fall_o      = fall_q;

endmodule

// File: rtl/model_tick_ctrl.sv
// Run/pause/single-step controller for the model clock, driven by UART command bytes.
//
// state  | meaning
// PAUSED | model_clk held low, counter cleared
// RUN    | free-running model clock
// STEP   | running until steps_left ticks have been issued
// DRAIN  | finishing the current high phase, then PAUSED
module model_tick_ctrl
   import model_tick_pkg::*;
#(
   parameter int unsigned RESET_SHIFT = 26,
   parameter bit          START_RUN   = 1'b1
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         cmd_data,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   output logic               model_clk,
   output logic               tick,
   output logic [CNT_W-1:0]   tick_count,
   output logic               running,
   output logic [SHIFT_W-1:0] shift
);

   state_e             state_q, state_d;
   logic [5:0]         steps_q, steps_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]   tick_count_q, tick_count_d;
   logic               enable, drain_done, fall;
   logic [2:0]         op;
   logic [4:0]         arg;

   assign op  = cmd_data[7:5];
   assign arg = cmd_data[4:0];

   // In DRAIN only a high phase may keep counting, so no new rise can start.
   assign enable     = (state_q == RUN) || (state_q == STEP) || ((state_q == DRAIN) && model_clk);
   assign drain_done = fall | ~model_clk;

   model_clk_prescaler u_prescaler (
      .clk         (clk),
      .rst         (rst),
      .shift_i     (shift_q),
      .enable_i    (enable),
      .model_clk_o (model_clk),
      .tick_o      (tick),
      .fall_o      (fall)
   );

   always_comb begin
      state_d      = state_q;
      steps_d      = steps_q;
      shift_d      = shift_q;
      tick_count_d = tick_count_q + CNT_W'(tick);
      if (cmd_valid && (op == OP_SHIFT)) shift_d = (arg == 5'd0) ? 5'd1 : arg;
      if (cmd_valid && (op == OP_CLR))   tick_count_d = '0;
      case (state_q)
         PAUSED: begin
            if (cmd_valid && (op == OP_RUN)) begin
               state_d = RUN;
            end else if (cmd_valid && (op == OP_STEP)) begin
               state_d = STEP;
               steps_d = {1'b0, arg} + 6'd1;
            end
         end
         RUN: begin
            if (cmd_valid && (op == OP_PAUSE)) state_d = DRAIN;
         end
         STEP: begin
            if (tick) steps_d = steps_q - 6'd1;
            if (cmd_valid && (op == OP_RUN))        state_d = RUN;
            else if (cmd_valid && (op == OP_PAUSE)) state_d = DRAIN;
            else if (tick && (steps_q == 6'd1))     state_d = DRAIN;
         end
         DRAIN: begin
            if (cmd_valid && (op == OP_RUN)) state_d = RUN;
            else if (drain_done)             state_d = PAUSED;
         end
         default: state_d = PAUSED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if (START_RUN) state_q <= RUN;
         else           state_q <= PAUSED;
         steps_q      <= '0;
         shift_q      <= SHIFT_W'(RESET_SHIFT);
         tick_count_q <= '0;
      end else begin
         state_q      <= state_d;
         steps_q      <= steps_d;
         shift_q      <= shift_d;
         tick_count_q <= tick_count_d;
      end
   end

   assign cmd_ready  = 1'b1;
   assign running    = (state_q != PAUSED);
   assign tick_count = tick_count_q;
   assign shift      = shift_q;

endmodule

// File: tb/tb_model_tick_ctrl.sv
// Bench for model_tick_ctrl: directed scenarios plus randomized single-step runs
// checked against period arithmetic derived from the command semantics.
module tb_model_tick_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cmd_data = 8'h00;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready, model_clk, tick, running;
   logic [15:0] tick_count;
   logic [4:0]  shift;

   int n_cmp = 0;
   int n_bad = 0;

   model_tick_ctrl #(.RESET_SHIFT(2), .START_RUN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .model_clk  (model_clk),
      .tick       (tick),
      .tick_count (tick_count),
      .running    (running),
      .shift      (shift)
   );

   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [7:0] b);
      cmd_data  = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
   endtask

   task automatic wait_tick(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (tick === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_paused();
      bit done;
      done = 1'b0;
      send(8'h40);
      for (int i = 0; i < 300; i++) begin
         if (running === 1'b0) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL pause_timeout: running=%b, required 0 within 300 cycles", running);
      end
   endtask

   task automatic test_reset();
      int exp_cnt;
      logic exp_mc, exp_tk;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({model_clk, tick, running, cmd_ready} !== 4'b0011 || tick_count !== 16'd0 || shift !== 5'd2) begin
         n_bad++;
         $display("FAIL reset_values: clk=%b tick=%b run=%b rdy=%b cnt=%h shift=%0d, required 0 0 1 1 0000 2",
                  model_clk, tick, running, cmd_ready, tick_count, shift);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (tick !== 1'b0 || model_clk !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_first_cycle: clk=%b tick=%b, required 0 0", model_clk, tick);
      end
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         exp_mc  = (k % 4) < 2;
         exp_tk  = (k % 4) == 0;
         exp_cnt = (k == 0) ? 0 : (k - 1) / 4 + 1;
         n_cmp++;
         if (model_clk !== exp_mc || tick !== exp_tk || tick_count !== 16'(exp_cnt)) begin
            n_bad++;
            $display("FAIL reset_run k=%0d: clk=%b tick=%b cnt=%0d, required %b %b %0d",
                     k, model_clk, tick, tick_count, exp_mc, exp_tk, exp_cnt);
         end
      end
   endtask

   task automatic test_step();
      logic exp_mc, exp_tk;
      send(8'h82);
      send(8'hA0);
      send(8'h62);
      for (int j = 0; j <= 16; j++) begin
         if (j > 0) @(negedge clk);
         exp_tk = (j == 2) || (j == 6) || (j == 10);
         exp_mc = (j >= 2) && (j < 12) && (((j - 2) % 4) < 2);
         n_cmp++;
         if (model_clk !== exp_mc || tick !== exp_tk) begin
            n_bad++;
            $display("FAIL step j=%0d: clk=%b tick=%b, required %b %b", j, model_clk, tick, exp_mc, exp_tk);
         end
      end
      n_cmp++;
      if (running !== 1'b0 || model_clk !== 1'b0 || tick_count !== 16'd3) begin
         n_bad++;
         $display("FAIL step_end: run=%b clk=%b cnt=%0d, required 0 0 3", running, model_clk, tick_count);
      end
   endtask

   task automatic test_pause_high();
      bit seen;
      send(8'h83);
      send(8'h20);
      wait_tick(40, seen);
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL pause_high_tick: tick=%b, required 1 within 40 cycles", tick);
      end
      send(8'h40);
      for (int j = 0; j <= 10; j++) begin
         if (j > 0) @(negedge clk);
         n_cmp++;
         if (model_clk !== (j < 3) || tick !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_high j=%0d: clk=%b tick=%b, required %b 0", j, model_clk, tick, (j < 3));
         end
      end
      n_cmp++;
      if (running !== 1'b0) begin
         n_bad++;
         $display("FAIL pause_high_run: running=%b, required 0", running);
      end
   endtask

   task automatic test_shift_change();
      bit   seen;
      logic exp_mc, exp_tk;
      send(8'h84);
      send(8'h20);
      wait_tick(40, seen);
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL shift_tick: tick=%b, required 1 within 40 cycles", tick);
      end
      repeat (5) @(negedge clk);
      send(8'h81);
      for (int j = 0; j <= 8; j++) begin
         if (j > 0) @(negedge clk);
         exp_tk = (j >= 2) && (j % 2 == 0);
         exp_mc = (j == 0) || exp_tk;
         n_cmp++;
         if (model_clk !== exp_mc || tick !== exp_tk) begin
            n_bad++;
            $display("FAIL shift_change j=%0d: clk=%b tick=%b, required %b %b", j, model_clk, tick, exp_mc, exp_tk);
         end
      end
      n_cmp++;
      if (shift !== 5'd1) begin
         n_bad++;
         $display("FAIL shift_value: shift=%0d, required 1", shift);
      end
   endtask

   task automatic test_count_wrap();
      bit          seen;
      logic [15:0] exp;
      force dut.tick_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.tick_count_q;
      exp = 16'hFFFE;
      send(8'h20);
      for (int i = 0; i < 3; i++) begin
         wait_tick(10, seen);
         @(negedge clk);
         exp = exp + 16'd1;
         n_cmp++;
         if (!seen || tick_count !== exp) begin
            n_bad++;
            $display("FAIL count_wrap i=%0d: seen=%b cnt=%h, required 1 %h", i, seen, tick_count, exp);
         end
      end
      wait_tick(10, seen);
      send(8'hA0);
      n_cmp++;
      if (!seen || tick_count !== 16'h0000) begin
         n_bad++;
         $display("FAIL clear_on_tick: seen=%b cnt=%h, required 1 0000", seen, tick_count);
      end
      wait_tick(10, seen);
      @(negedge clk);
      n_cmp++;
      if (!seen || tick_count !== 16'h0001) begin
         n_bad++;
         $display("FAIL count_after_clear: seen=%b cnt=%h, required 1 0001", seen, tick_count);
      end
   endtask

   task automatic test_ignored_and_reset();
      int ntk;
      send(8'hC0);
      send(8'hE0);
      send(8'h61);
      ntk = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tick === 1'b1) ntk++;
      end
      n_cmp++;
      if (ntk != 10 || running !== 1'b1 || shift !== 5'd1) begin
         n_bad++;
         $display("FAIL ignored_ops: ticks=%0d run=%b shift=%0d, required 10 1 1", ntk, running, shift);
      end
      wait_paused();
      send(8'h7F);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({model_clk, tick, running, cmd_ready} !== 4'b0011 || tick_count !== 16'd0 || shift !== 5'd2) begin
         n_bad++;
         $display("FAIL async_reset: clk=%b tick=%b run=%b rdy=%b cnt=%h shift=%0d, required 0 0 1 1 0000 2",
                  model_clk, tick, running, cmd_ready, tick_count, shift);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      n_cmp++;
      if (running !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_discards_step: running=%b, required 1", running);
      end
   endtask

   task automatic test_random_steps();
      int   sh, n, h, p, last;
      logic exp_mc, exp_tk;
      wait_paused();
      for (int it = 0; it < 6; it++) begin
         sh = $urandom_range(3, 1);
         n  = $urandom_range(7, 0);
         h  = 1 << (sh - 1);
         p  = 2 * h;
         send(8'h80 | 8'(sh));
         send(8'hA0);
         if ($urandom_range(1, 0) == 1) send(8'h00);
         send(8'h60 | 8'(n));
         last = p * (n + 1) + 4;
         for (int j = 0; j <= last; j++) begin
            if (j > 0) @(negedge clk);
            exp_mc = (j >= h) && (j < p * (n + 1)) && (((j - h) % p) < h);
            exp_tk = (j >= h) && (j < p * (n + 1)) && (((j - h) % p) == 0);
            n_cmp++;
            if (model_clk !== exp_mc || tick !== exp_tk) begin
               n_bad++;
               $display("FAIL rand_step it=%0d sh=%0d n=%0d j=%0d: clk=%b tick=%b, required %b %b",
                        it, sh, n, j, model_clk, tick, exp_mc, exp_tk);
            end
         end
         n_cmp++;
         if (running !== 1'b0 || tick_count !== 16'(n + 1)) begin
            n_bad++;
            $display("FAIL rand_step_end it=%0d: run=%b cnt=%0d, required 0 %0d", it, running, tick_count, n + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      wait_paused();
      test_step();
      test_pause_high();
      test_shift_change();
      wait_paused();
      test_count_wrap();
      test_ignored_and_reset();
      test_random_steps();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
